tdp_ram_param: RTL and testbench

// - Parametrised single-clock true dual-port RAM; next generation of the team's 8x64 TDP RAM.
// - Adds generic width/depth, byte enables, per-port enables, a read-valid strobe,

---
 rtl/tdp_ram_param.sv | 144 ++++++++++++++
 tb/tb_tdp_ram_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tdp_ram_param.sv
// Single-clock true dual-port RAM with byte enables, read-valid strobes and a collision flag.
// Define TDP_RAM_PARITY_EN to add per-byte even parity storage and the perr_a/perr_b outputs.
module tdp_ram_param #(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int WR_MODE = 0,
  parameter int A_PRIO  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_a,
  input  logic            we_a,
  input  logic [DW/8-1:0] be_a,
  input  logic [AW-1:0]   addr_a,
  input  logic [DW-1:0]   din_a,
  output logic [DW-1:0]   dout_a,
  output logic            vld_a,
  input  logic            en_b,
  input  logic            we_b,
  input  logic [DW/8-1:0] be_b,
  input  logic [AW-1:0]   addr_b,
  input  logic [DW-1:0]   din_b,
  output logic [DW-1:0]   dout_b,
  output logic            vld_b,
  output logic            coll
`ifdef TDP_RAM_PARITY_EN
  ,
  output logic            perr_a,
  output logic            perr_b
`endif
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  logic [NB-1:0] wmask_a, wmask_b;
  logic [DW-1:0] rd_a, rd_b;
  logic [DW-1:0] dout_a_d, dout_a_q, dout_b_d, dout_b_q;
  logic          vld_a_d, vld_a_q, vld_b_d, vld_b_q;
  logic          coll_d, coll_q;

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [NB-1:0] be);
    logic [DW-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // On a same-address write/write the losing port gives up only the bytes both ports enabled.
  always_comb begin
    wmask_a = (en_a && we_a) ? be_a : '0;
    wmask_b = (en_b && we_b) ? be_b : '0;
    if (addr_a == addr_b) begin
      if (A_PRIO != 0) wmask_b = wmask_b & ~wmask_a;
      else             wmask_a = wmask_a & ~wmask_b;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wmask_a[i]) mem_q[addr_a][8*i +: 8] <= din_a[8*i +: 8];
      if (wmask_b[i]) mem_q[addr_b][8*i +: 8] <= din_b[8*i +: 8];
    end
  end

  always_comb begin
    rd_a     = mem_q[addr_a];
    rd_b     = mem_q[addr_b];
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    if (en_a) dout_a_d = (WR_MODE != 0 && we_a) ? merge_bytes(rd_a, din_a, be_a) : rd_a;
    if (en_b) dout_b_d = (WR_MODE != 0 && we_b) ? merge_bytes(rd_b, din_b, be_b) : rd_b;
    vld_a_d  = en_a;
    vld_b_d  = en_b;
    coll_d   = en_a && en_b && (addr_a == addr_b) && (we_a || we_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
      vld_a_q  <= 1'b0;
      vld_b_q  <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
      vld_a_q  <= vld_a_d;
      vld_b_q  <= vld_b_d;
      coll_q   <= coll_d;
    end
  end

  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;
  assign vld_a  = vld_a_q;
  assign vld_b  = vld_b_q;
  assign coll   = coll_q;

`ifdef TDP_RAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] bad_a, bad_b;
  logic          perr_a_d, perr_a_q, perr_b_d, perr_b_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wmask_a[i]) par_q[addr_a][i] <= ^din_a[8*i +: 8];
      if (wmask_b[i]) par_q[addr_b][i] <= ^din_b[8*i +: 8];
    end
  end

  // In write-first mode the freshly written bytes bypass storage, so they cannot fail.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      bad_a[i] = (^rd_a[8*i +: 8]) != par_q[addr_a][i];
      bad_b[i] = (^rd_b[8*i +: 8]) != par_q[addr_b][i];
    end
    if (WR_MODE != 0 && we_a) bad_a = bad_a & ~be_a;
    if (WR_MODE != 0 && we_b) bad_b = bad_b & ~be_b;
    perr_a_d = en_a && (|bad_a);
    perr_b_d = en_b && (|bad_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_a_q <= 1'b0;
      perr_b_q <= 1'b0;
    end else begin
      perr_a_q <= perr_a_d;
      perr_b_q <= perr_b_d;
    end
  end

  assign perr_a = perr_a_q;
  assign perr_b = perr_b_q;
`endif

endmodule

// File: tb/tb_tdp_ram_param.sv
// Self-checking bench for tdp_ram_param: directed cases plus random traffic against a word-level model.
// Parity checks are included when TDP_RAM_PARITY_EN is defined.
module tb_tdp_ram_param;

  localparam int DW      = 32;
  localparam int AW      = 8;
  localparam int WR_MODE = 0;
  localparam int A_PRIO  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [3:0]  be_a = '0, be_b = '0;
  logic [7:0]  addr_a = '0, addr_b = '0;
  logic [31:0] din_a = '0, din_b = '0;
  logic [31:0] dout_a, dout_b;
  logic        vld_a, vld_b, coll;
`ifdef TDP_RAM_PARITY_EN
  logic        perr_a, perr_b;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem [256];
  bit          corrupt [256];
  logic [31:0] exp_dout_a = '0, exp_dout_b = '0;
  logic        exp_vld_a = 1'b0, exp_vld_b = 1'b0, exp_coll = 1'b0;
  logic        exp_perr_a = 1'b0, exp_perr_b = 1'b0;

  tdp_ram_param #(.DW(DW), .AW(AW), .WR_MODE(WR_MODE), .A_PRIO(A_PRIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a), .vld_a(vld_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b), .vld_b(vld_b),
    .coll(coll)
`ifdef TDP_RAM_PARITY_EN
    , .perr_a(perr_a), .perr_b(perr_b)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Byte-enable write expressed as a mask blend.
  function automatic logic [31:0] blend(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      $error("[TB] %s did not match", tag);
    end
  endtask

  task automatic checkPorts(input string tag);
    checkOutput({tag, ".dout_a"}, dout_a, exp_dout_a);
    checkOutput({tag, ".vld_a"}, 32'(vld_a), 32'(exp_vld_a));
    checkOutput({tag, ".dout_b"}, dout_b, exp_dout_b);
    checkOutput({tag, ".vld_b"}, 32'(vld_b), 32'(exp_vld_b));
    checkOutput({tag, ".coll"}, 32'(coll), 32'(exp_coll));
`ifdef TDP_RAM_PARITY_EN
    checkOutput({tag, ".perr_a"}, 32'(perr_a), 32'(exp_perr_a));
    checkOutput({tag, ".perr_b"}, 32'(perr_b), 32'(exp_perr_b));
`endif
  endtask

  // Drives one cycle, predicts the outputs from the model and advances it, then checks after the edge.
  task automatic applyStimulus(input string tag,
                               input logic ea, input logic wa, input logic [3:0] ba,
                               input logic [7:0] aa, input logic [31:0] da,
                               input logic eb, input logic wb, input logic [3:0] bb,
                               input logic [7:0] ab, input logic [31:0] db);
    logic [31:0] old_a, old_b;
    logic        write_a, write_b;
    @(negedge clk);
    en_a = ea; we_a = wa; be_a = ba; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; be_b = bb; addr_b = ab; din_b = db;

    old_a   = ref_mem[aa];
    old_b   = ref_mem[ab];
    write_a = ea && wa;
    write_b = eb && wb;
    if (ea) exp_dout_a = (write_a && WR_MODE == 1) ? blend(old_a, da, ba) : old_a;
    if (eb) exp_dout_b = (write_b && WR_MODE == 1) ? blend(old_b, db, bb) : old_b;
    exp_vld_a  = ea;
    exp_vld_b  = eb;
    exp_perr_a = ea && corrupt[aa] && !(WR_MODE == 1 && wa && ba[0]);
    exp_perr_b = eb && corrupt[ab] && !(WR_MODE == 1 && wb && bb[0]);
    exp_coll   = ea && eb && (aa == ab) && (wa || wb);

    if (write_a && write_b && aa == ab) begin
      if (A_PRIO == 1) ref_mem[aa] = blend(blend(old_a, db, bb), da, ba);
      else             ref_mem[aa] = blend(blend(old_a, da, ba), db, bb);
    end else begin
      if (write_a) ref_mem[aa] = blend(ref_mem[aa], da, ba);
      if (write_b) ref_mem[ab] = blend(ref_mem[ab], db, bb);
    end
    if (write_a && ba[0]) corrupt[aa] = 1'b0;
    if (write_b && bb[0]) corrupt[ab] = 1'b0;

    @(posedge clk);
    #1;
    checkPorts(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 0, 0, 4'h0, 8'h00, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) corrupt[i] = 1'b0;

    // Power-on reset
    #1 rst_n = 1'b0;
    #1 checkPorts("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole array so every later read has a known value
    for (int i = 0; i < 128; i++)
      applyStimulus("fill", 1, 1, 4'hF, 8'(2*i), $urandom, 1, 1, 4'hF, 8'(2*i+1), $urandom);

    // Write on A, read back on B
    applyStimulus("t2_wr", 1, 1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 0, 4'h0, 8'h00, 32'h0);
    applyStimulus("t2_rd", 0, 0, 4'h0, 8'h00, 32'h0, 1, 0, 4'h0, 8'h10, 32'h0);
    checkOutput("t2_dout_b", dout_b, 32'hDEADBEEF);
    checkOutput("t2_vld_b", 32'(vld_b), 32'd1);
    idle("t2_idle");
    checkOutput("t2_vld_b_drop", 32'(vld_b), 32'd0);
    checkOutput("t2_dout_b_hold", dout_b, 32'hDEADBEEF);

    // Partial byte-enable write
    applyStimulus("t3_init", 1, 1, 4'hF, 8'h20, 32'h11223344, 0, 0, 4'h0, 8'h00, 32'h0);
    applyStimulus("t3_wr", 1, 1, 4'b0101, 8'h20, 32'hAABBCCDD, 0, 0, 4'h0, 8'h00, 32'h0);
    applyStimulus("t3_rd", 1, 0, 4'h0, 8'h20, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
    checkOutput("t3_dout_a", dout_a, 32'h11BB33DD);

    // Zero byte enables write nothing but still return data
    applyStimulus("t3_be0", 1, 1, 4'h0, 8'h20, 32'hFFFFFFFF, 0, 0, 4'h0, 8'h00, 32'h0);
    checkOutput("t3_be0_dout_a", dout_a, 32'h11BB33DD);
    checkOutput("t3_be0_vld_a", 32'(vld_a), 32'd1);

    // Same-port read-during-write
    applyStimulus("t4_init", 1, 1, 4'hF, 8'h05, 32'h1, 0, 0, 4'h0, 8'h00, 32'h0);
    applyStimulus("t4_wr", 1, 1, 4'hF, 8'h05, 32'h2, 0, 0, 4'h0, 8'h00, 32'h0);
    checkOutput("t4_dout_a", dout_a, (WR_MODE == 0) ? 32'h1 : 32'h2);

    // Write/write collision, then read/write collision
    applyStimulus("t5_ww", 1, 1, 4'hF, 8'h30, 32'hAAAAAAAA, 1, 1, 4'hF, 8'h30, 32'h55555555);
    checkOutput("t5_coll_ww", 32'(coll), 32'd1);
    applyStimulus("t5_rd", 1, 0, 4'h0, 8'h30, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
    checkOutput("t5_mem", dout_a, (A_PRIO == 1) ? 32'hAAAAAAAA : 32'h55555555);
    checkOutput("t5_coll_drop", 32'(coll), 32'd0);
    applyStimulus("t5_rw", 1, 0, 4'h0, 8'h30, 32'h0, 1, 1, 4'hF, 8'h30, 32'h12345678);
    checkOutput("t5_rw_dout_a", dout_a, (A_PRIO == 1) ? 32'hAAAAAAAA : 32'h55555555);
    checkOutput("t5_coll_rw", 32'(coll), 32'd1);
    applyStimulus("t5_rr", 1, 0, 4'h0, 8'h30, 32'h0, 1, 0, 4'h0, 8'h30, 32'h0);
    checkOutput("t5_rr_same", dout_b, 32'h12345678);
    checkOutput("t5_coll_rr", 32'(coll), 32'd0);

`ifdef TDP_RAM_PARITY_EN
    // Corrupt one stored bit behind the parity
    @(negedge clk);
    dut.mem_q[8'h40][0] = ~dut.mem_q[8'h40][0];
    ref_mem[8'h40] = ref_mem[8'h40] ^ 32'h1;
    corrupt[8'h40] = 1'b1;
    applyStimulus("t6_bad", 1, 0, 4'h0, 8'h40, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
    checkOutput("t6_perr_a", 32'(perr_a), 32'd1);
    applyStimulus("t6_good", 1, 0, 4'h0, 8'h41, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
    checkOutput("t6_perr_a_clean", 32'(perr_a), 32'd0);
    applyStimulus("t6_fix", 1, 1, 4'hF, 8'h40, $urandom, 0, 0, 4'h0, 8'h00, 32'h0);
`endif

    // Random traffic on a narrow address window to provoke collisions
    for (int i = 0; i < 400; i++)
      applyStimulus("rand",
                    $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 8'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 8'($urandom_range(0, 7)), $urandom);

    // Reset in the middle of a read cycle
    @(negedge clk);
    en_a = 1'b1; we_a = 1'b0; addr_a = 8'h10;
    en_b = 1'b1; we_b = 1'b0; addr_b = 8'h11;
    #2 rst_n = 1'b0;
    exp_dout_a = '0; exp_dout_b = '0;
    exp_vld_a = 1'b0; exp_vld_b = 1'b0; exp_coll = 1'b0;
    exp_perr_a = 1'b0; exp_perr_b = 1'b0;
    #1 checkPorts("t1_reset");
    en_a = 1'b0; en_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle("t1_release0");
    idle("t1_release1");
    applyStimulus("t1_after", 1, 0, 4'h0, 8'h10, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
    checkOutput("t1_after_dout_a", dout_a, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
